// File: rtl/draw_bcg_tiled.sv
// draw_bcg_tiled: tiles the background ROM image across active video with matched VGA timing
module draw_bcg_tiled #(
  parameter int IMG_W = 48,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] pixel_addr,
  input  logic [11:0] rgb_pixel,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  typedef struct packed {
    logic        en;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic [10:0] h;
    logic [10:0] v;
  } stage_t;
  logic [5:0] tile_x, tile_y, tile_x_nxt, tile_y_nxt;
  stage_t p1, p2;
  // next tile position: x restarts every line, y advances at each line start
  always_comb begin
    tile_x_nxt = (hcount_in == 11'd0 || tile_x == 6'(IMG_W - 1)) ? 6'd0 : tile_x + 6'd1;
    tile_y_nxt = hcount_in != 11'd0 ? tile_y :
                 (vcount_in == 11'd0 || tile_y == 6'(IMG_H - 1)) ? 6'd0 : tile_y + 6'd1;
  end
  // tile counters and ROM address, registered on the same edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tile_x     <= '0;
      tile_y     <= '0;
      pixel_addr <= '0;
    end else begin
      tile_x     <= tile_x_nxt;
      tile_y     <= tile_y_nxt;
      pixel_addr <= {tile_y_nxt, tile_x_nxt};
    end
  // two-stage delay so timing, enable and bypass colour line up with ROM data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= '{en, hblnk_in, vblnk_in, hsync_in, vsync_in, rgb_in, hcount_in, vcount_in};
      p2 <= p1;
    end
  // output register: blank wins, then ROM image or bypass colour
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= p2.h;
      vcount_out <= p2.v;
      hsync_out  <= p2.hs;
      vsync_out  <= p2.vs;
      hblnk_out  <= p2.hb;
      vblnk_out  <= p2.vb;
      rgb_out    <= (p2.hb || p2.vb) ? 12'h000 : p2.en ? rgb_pixel : p2.rgb;
    end
endmodule

// File: tb/tb_draw_bcg_tiled.sv
// tb_draw_bcg_tiled: raster-driven scoreboard plus fixed probe table for draw_bcg_tiled
module tb_draw_bcg_tiled;
  localparam int HT = 320, VT = 70, HB = 256, VB = 66, NV = 15;
  logic clk = 0, rst = 0, en = 0;
  logic [10:0] hcount_in = 0, vcount_in = 0, hcount_out, vcount_out;
  logic hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in = 0, pixel_addr, rgb_pixel = 0, rgb_out;
  typedef struct {int h; int v; logic en; logic [11:0] rgb; logic [11:0] addr; logic [11:0] rgbo;} vec_t;
  typedef struct {logic chk; logic [10:0] h; logic [10:0] v; logic hs; logic vs; logic hb; logic vb; logic [11:0] rgb;} exp_t;
  vec_t tbl[NV];
  exp_t q[$];
  int tests = 0, fails = 0;
  logic x_ok = 0, y_ok = 0;

  draw_bcg_tiled #(.IMG_W(48), .IMG_H(64)) dut (
    .clk(clk), .rst(rst), .en(en), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rgb_pixel <= pixel_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_addr"}, pixel_addr, 0);
    check({tag, "_hcount"}, hcount_out, 0);
    check({tag, "_vcount"}, vcount_out, 0);
    check({tag, "_flags"}, {hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    check({tag, "_rgb"}, rgb_out, 0);
  endtask

  task automatic prime();
    exp_t z;
    z = '{chk: 1'b1, h: '0, v: '0, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: '0};
    q.delete();
    q.push_back(z);
    q.push_back(z);
    x_ok = 0;
    y_ok = 0;
  endtask

  task automatic drive_raster(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = h >= HB;
    vblnk_in  = v >= VB;
    hsync_in  = h >= 270 && h < 290;
    vsync_in  = v >= 67 && v < 69;
  endtask

  task automatic hold_rst(input int h, input int v);
    @(negedge clk);
    rst = 0;
    drive_raster(h, v);
    prime();
    #1 zero_check("midrst");
    @(posedge clk);
    #1 zero_check("midrst_hold");
  endtask

  task automatic step(input int f, input int h, input int v);
    exp_t e, o;
    logic [11:0] a;
    int k;
    k = -1;
    if (f == 0) for (int i = 0; i < NV; i++) if (tbl[i].h == h && tbl[i].v == v) k = i;
    @(negedge clk);
    rst = 1;
    drive_raster(h, v);
    en = k >= 0 ? tbl[k].en : 1'($urandom_range(0, 5) != 0);
    rgb_in = k >= 0 ? tbl[k].rgb : 12'($urandom);
    if (h == 0) x_ok = 1;
    if (h == 0 && v == 0) y_ok = 1;
    a = {6'(v % 64), 6'(h % 48)};
    e.chk = 1;
    e.h = hcount_in;
    e.v = vcount_in;
    e.hs = hsync_in;
    e.vs = vsync_in;
    e.hb = hblnk_in;
    e.vb = vblnk_in;
    if (hblnk_in || vblnk_in) e.rgb = 12'h000;
    else if (!en) e.rgb = rgb_in;
    else begin
      e.rgb = a;
      e.chk = x_ok && y_ok;
    end
    if (k >= 0) begin
      e.rgb = tbl[k].rgbo;
      e.chk = 1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (k >= 0) check("tbl_addr", pixel_addr, tbl[k].addr);
    else begin
      if (x_ok) check("addr_x", pixel_addr[5:0], a[5:0]);
      if (y_ok) check("addr_y", pixel_addr[11:6], a[11:6]);
    end
    if (q.size() == 3) begin
      o = q.pop_front();
      check("hcount_out", hcount_out, o.h);
      check("vcount_out", vcount_out, o.v);
      check("syncs", {hsync_out, vsync_out}, {o.hs, o.vs});
      check("blanks", {hblnk_out, vblnk_out}, {o.hb, o.vb});
      if (o.chk) check("rgb_out", rgb_out, o.rgb);
    end else check("sb_depth", q.size(), 3);
  endtask

  initial begin
    tbl[0]  = '{0,   0,  1'b1, 12'h000, 12'h000, 12'h000};
    tbl[1]  = '{10,  0,  1'b1, 12'h000, 12'h00A, 12'h00A};
    tbl[2]  = '{46,  5,  1'b1, 12'h000, 12'h16E, 12'h16E};
    tbl[3]  = '{47,  5,  1'b1, 12'h000, 12'h16F, 12'h16F};
    tbl[4]  = '{48,  5,  1'b1, 12'h000, 12'h140, 12'h140};
    tbl[5]  = '{49,  5,  1'b1, 12'h000, 12'h141, 12'h141};
    tbl[6]  = '{96,  5,  1'b1, 12'h000, 12'h140, 12'h140};
    tbl[7]  = '{260, 5,  1'b1, 12'h000, 12'h154, 12'h000};
    tbl[8]  = '{10,  3,  1'b1, 12'h000, 12'h0CA, 12'h0CA};
    tbl[9]  = '{20,  3,  1'b0, 12'hF0F, 12'h0D4, 12'hF0F};
    tbl[10] = '{21,  3,  1'b1, 12'h000, 12'h0D5, 12'h0D5};
    tbl[11] = '{5,   63, 1'b1, 12'h000, 12'hFC5, 12'hFC5};
    tbl[12] = '{5,   64, 1'b1, 12'h000, 12'h005, 12'h005};
    tbl[13] = '{5,   65, 1'b1, 12'h000, 12'h045, 12'h045};
    tbl[14] = '{85,  69, 1'b1, 12'h000, 12'h165, 12'h000};
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_raster($urandom_range(0, HT - 1), $urandom_range(0, VT - 1));
      en = 1'($urandom);
      rgb_in = 12'($urandom);
      @(posedge clk);
      #1 zero_check("rst");
    end
    prime();
    for (int f = 0; f < 3; f++)
      for (int v = 0; v < (f == 2 ? 4 : VT); v++)
        for (int h = 0; h < HT; h++)
          if (f == 1 && v == 40 && h >= 300 && h < 304) hold_rst(h, v);
          else step(f, h, v);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
